// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-schedule FSM states and the
// forward S-box with the word helpers used by the key schedule.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CALC
  } ks_state_t;

  // Row-major forward S-box; entry 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = sbox(w[8*i +: 8]);
    end
    return r;
  endfunction

endpackage

// File: rtl/rcon.sv
// AES round-constant ROM with a registered one-cycle read.
// Addresses 0..9 hold rcon[1..10]; all other addresses read as zero.
module rcon (
  input  logic       clk,
  input  logic [3:0] addr,
  output logic [7:0] out
);

  function automatic logic [7:0] rcon_entry(input int i);
    case (i)
      0:       return 8'h01;
      1:       return 8'h02;
      2:       return 8'h04;
      3:       return 8'h08;
      4:       return 8'h10;
      5:       return 8'h20;
      6:       return 8'h40;
      7:       return 8'h80;
      8:       return 8'h1b;
      9:       return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] rom [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_rom
    assign rom[gi] = rcon_entry(gi);
  end

  always_ff @(posedge clk) begin
    out <= rom[addr];
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: emits round keys 0..10, one every two cycles after
// key 0, using a FETCH cycle to let the registered rcon ROM settle.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         done
);

  ks_state_t    state_reg, state_next;
  logic [3:0]   rnd_reg, rnd_next;
  logic [127:0] key_reg, key_next;
  logic [127:0] round_key_reg, round_key_next;
  logic [3:0]   rk_index_reg, rk_index_next;
  logic         rk_valid_reg, rk_valid_next;
  logic         done_reg, done_next;

  logic [3:0]   rcon_addr;
  logic [7:0]   rcon_out;
  logic [31:0]  temp;
  logic [31:0]  w0_next, w1_next, w2_next, w3_next;

  // Address stays at rnd-1 through FETCH, so rcon_out is valid in CALC.
  assign rcon_addr = rnd_reg - 4'd1;

  rcon u_rcon (
    .clk  (clk),
    .addr (rcon_addr),
    .out  (rcon_out)
  );

  assign temp    = sub_word(rot_word(key_reg[31:0])) ^ {rcon_out, 24'h0};
  assign w0_next = key_reg[127:96] ^ temp;
  assign w1_next = key_reg[95:64]  ^ w0_next;
  assign w2_next = key_reg[63:32]  ^ w1_next;
  assign w3_next = key_reg[31:0]   ^ w2_next;

  always_comb begin
    state_next     = state_reg;
    rnd_next       = rnd_reg;
    key_next       = key_reg;
    round_key_next = round_key_reg;
    rk_index_next  = rk_index_reg;
    rk_valid_next  = 1'b0;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          key_next       = key_in;
          round_key_next = key_in;
          rk_valid_next  = 1'b1;
          rk_index_next  = 4'd0;
          rnd_next       = 4'd1;
          state_next     = FETCH;
        end
      end
      FETCH: begin
        state_next = CALC;
      end
      CALC: begin
        key_next       = {w0_next, w1_next, w2_next, w3_next};
        round_key_next = {w0_next, w1_next, w2_next, w3_next};
        rk_valid_next  = 1'b1;
        rk_index_next  = rnd_reg;
        if (rnd_reg == 4'(NR)) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          rnd_next   = rnd_reg + 4'd1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rnd_reg       <= '0;
      key_reg       <= '0;
      round_key_reg <= '0;
      rk_index_reg  <= '0;
      rk_valid_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rnd_reg       <= rnd_next;
      key_reg       <= key_next;
      round_key_reg <= round_key_next;
      rk_index_reg  <= rk_index_next;
      rk_valid_reg  <= rk_valid_next;
      done_reg      <= done_next;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign rk_valid  = rk_valid_reg;
  assign rk_index  = rk_index_reg;
  assign round_key = round_key_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: stimulus queues expected strobes,
// a negedge monitor pops and checks each rk_valid against the queue.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, rk_valid, done;
  logic [3:0]   rk_index;
  logic [127:0] round_key;

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_index  (rk_index),
    .round_key (round_key),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    int           idx;
    logic [127:0] key;
    bit           known;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%032h required=%032h", name, act, exp);
    end
  endtask

  // Key i of an expansion accepted at edge t is seen at the negedge with cyc == t+2i.
  task automatic push_seq(input int t, input logic [127:0] k0, input logic [127:0] k1,
                          input logic [127:0] k10);
    exp_t e;
    for (int i = 0; i <= 10; i++) begin
      e.idx   = i;
      e.cyc   = t + 2 * i;
      e.known = (i == 0) || (i == 1) || (i == 10);
      e.key   = (i == 0) ? k0 : (i == 1) ? k1 : k10;
      q.push_back(e);
    end
  endtask

  task automatic issue(input logic [127:0] k0, input logic [127:0] k1, input logic [127:0] k10);
    start  = 1'b1;
    key_in = k0;
    push_seq(cyc + 1, k0, k1, k10);
    @(negedge clk);
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 128'(q.size()), 128'd0);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rk_valid) begin
      pulses++;
      $display("strobe cyc=%0d index=%0d key=%032h done=%0b busy=%0b",
               cyc, rk_index, round_key, done, busy);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rk_valid index=%0d required=no strobe", rk_index);
      end else begin
        e = q.pop_front();
        chk("rk_index", 128'(rk_index), 128'(e.idx));
        chk("rk_cycle", 128'(cyc), 128'(e.cyc));
        chk("done_at_strobe", 128'(done), 128'(e.idx == 10));
        chk("busy_at_strobe", 128'(busy), 128'(e.idx != 10));
        if (e.known) chk("round_key", round_key, e.key);
      end
    end else if (done) begin
      checks++;
      errors++;
      $display("FAIL done_without_strobe actual=1 required=0");
    end
  end

  initial begin : stimulus
    int t;
    int p0;

    // Reset held three cycles, then start while still in reset.
    repeat (3) @(negedge clk);
    chk("reset_round_key", round_key, 128'd0);
    chk("reset_ctrl", 128'({busy, done, rk_valid, rk_index}), 128'd0);
    start  = 1'b1;
    key_in = FIPS_K0;
    repeat (4) begin
      @(negedge clk);
      chk("start_in_reset", 128'({busy, rk_valid}), 128'd0);
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 128'({busy, rk_valid, done}), 128'd0);

    issue(FIPS_K0, FIPS_K1, FIPS_K10);
    drain("fips_drain");

    p0 = pulses;
    issue(128'd0, ZERO_K1, ZERO_K10);
    drain("zero_drain");
    chk("zero_pulse_count", 128'(pulses - p0), 128'd11);

    // A second start mid-expansion must be ignored.
    t = cyc + 1;
    issue(FIPS_K0, FIPS_K1, FIPS_K10);
    while (cyc < t + 4) @(negedge clk);
    start  = 1'b1;
    key_in = ALT_KEY;
    @(negedge clk);
    start  = 1'b0;
    drain("ignore_drain");

    // Reset mid-expansion abandons the run.
    p0 = pulses;
    t  = cyc + 1;
    issue(128'd0, ZERO_K1, ZERO_K10);
    while (cyc < t + 7) @(negedge clk);
    rst = 1'b1;
    q.delete();
    chk("pulses_before_rst", 128'(pulses - p0), 128'd4);
    @(negedge clk);
    chk("rst_mid_round_key", round_key, 128'd0);
    chk("rst_mid_ctrl", 128'({busy, done, rk_valid, rk_index}), 128'd0);
    rst = 1'b0;
    p0  = pulses;
    repeat (8) @(negedge clk);
    chk("no_strobe_after_rst", 128'(pulses - p0), 128'd0);
    issue(FIPS_K0, FIPS_K1, FIPS_K10);
    drain("restart_drain");

    // start held high: the second run is accepted on the done cycle.
    t      = cyc + 1;
    start  = 1'b1;
    key_in = FIPS_K0;
    push_seq(t, FIPS_K0, FIPS_K1, FIPS_K10);
    push_seq(t + 21, 128'd0, ZERO_K1, ZERO_K10);
    @(negedge clk);
    key_in = 128'd0;
    while (cyc < t + 21) @(negedge clk);
    start  = 1'b0;
    key_in = ALT_KEY;
    drain("b2b_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

AES-128 key-schedule engine. It takes a 128-bit cipher key and emits the 11 round keys (index 0–10) one at a time over a valid strobe. It sits directly upstream of the round datapath and internally drives the existing `rcon` round-constant ROM, which has a registered one-cycle read. It is the only consumer of that ROM.

## Interface
- No parameters. Nr = 10 is a package constant.
- `clk`  in  1  — single clock, all logic on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — begin expansion; sampled only in IDLE.
- `key_in`  in  128  — cipher key; byte 0 is `[127:120]`; sampled on the accepting edge only.
- `busy`  out  1  — expansion in progress.
- `rk_valid`  out  1  — one-cycle strobe; `round_key`/`rk_index` valid.
- `rk_index`  out  4  — round number 0–10 of the presented key.
- `round_key`  out  128  — round key; word w0 = `[127:96]`.
- `done`  out  1  — one-cycle pulse coincident with the index-10 `rk_valid`.

## Operation
- FSM states: IDLE, FETCH, CALC.
- **IDLE:**
  - If `start` = 1 at an edge:
    - `round_key` and the internal key register load `key_in`.
    - `rk_valid` ← 1, `rk_index` ← 0.
    - Round counter `rnd` ← 1; state → FETCH.
  - Otherwise stay in IDLE.
- **FETCH:** one wait cycle while the rcon ROM registers `rcon[rnd-1]`. The ROM address is driven combinationally as `rnd-1` (4 bits) in every state.
- **CALC:** compute and register the next round key from the previous key w0..w3:
  - `temp = SubWord(RotWord(w3)) ^ {rcon_out, 24'h0}`
  - `w0' = w0^temp`, `w1' = w1^w0'`, `w2' = w2^w1'`, `w3' = w3^w2'`
  - RotWord rotates left one byte. SubWord applies the S-box per byte.
  - At the edge: `rk_valid` ← 1, `rk_index` ← `rnd`.
  - If `rnd` = 10: `done` ← 1, state → IDLE.
  - Else: `rnd` ← `rnd`+1, state → FETCH.
- `rk_valid` and `done` are 0 in every cycle not listed above.
- `round_key` and `rk_index` hold their last value between strobes.
- `start` while not IDLE is ignored; no queuing. `key_in` changes after acceptance have no effect.
- `start` in the same cycle that `done` is asserted (FSM already in IDLE) is accepted, giving back-to-back expansions.
- `rst` at any time, including mid-expansion, overrides everything:
  - State → IDLE.
  - `rnd`, `round_key`, the internal key register, `rk_index`, `rk_valid`, `busy`, `done` all → 0.
  - An expansion in flight is abandoned; no further strobes follow.

## Timing
- Reset values: all outputs 0.
- `start` sampled high at edge T:
  - key 0 presented in cycle T+1.
  - key i (1 ≤ i ≤ 10) presented in cycle T+1+2i, so key 10 with `done` in cycle T+21.
- `busy` = (state ≠ IDLE): high for cycles T+1..T+20, low in T+21.
- The rcon ROM read has exactly one cycle of latency. The address must be stable throughout FETCH and is consumed in CALC.
- No back-pressure. The consumer must capture each key on its `rk_valid` cycle.

## Structure
- Shared package `aes_pkg`:
  - `localparam NR = 10`
  - FSM state enum `ks_state_t` (IDLE, FETCH, CALC)
  - `function sbox(input [7:0])`: the full 256-entry forward S-box, combinational, shared with the SubBytes stage
  - helper functions `rot_word` and `sub_word`
- One sub-module: the existing `rcon` instantiated as `u_rcon`, with `addr` = `rnd-1` and `out` → `rcon_out`.
- No other hierarchy.

## Test plan
- **Reset:** hold `rst` 3 cycles → all outputs 0. Then pulse `start` with `rst` still high → no `rk_valid`, `busy` stays 0.
- **FIPS-197 key** `2b7e151628aed2a6abf7158809cf4f3c`:
  - key 0 = input at T+1
  - key 1 = `a0fafe1788542cb123a339392a6c7605` at T+3
  - key 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6` at T+21, with `done` = 1 and `busy` = 0
- **All-zero key:**
  - key 1 = `62636363626363636263636362636363`
  - key 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`
  - exactly 11 `rk_valid` pulses with indices 0..10 in order
- **`start` re-asserted at T+5 with a different `key_in`:** ignored; the sequence matches the original key and completes at T+21.
- **`rst` asserted at T+8:** outputs 0 next cycle and no further `rk_valid`. A new `start` afterwards produces a correct full sequence from key 0.
- **Back-to-back:** `start` held high continuously → the second expansion accepted at the `done` cycle (T+21). Its key 0 appears at T+22 and its key 10 at T+42.
